// File: rtl/serial_arith_pkg.sv
// Shared definitions for the serial arithmetic blocks: FSM encoding and
// elaboration-time parameter checks.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // True when the width can be split into whole digits.
    function automatic bit width_ok(int unsigned width, int unsigned digit);
        return (width >= 2) && (digit >= 1) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit ripple adder; also exposes the carry into its top
// bit so the caller can form the signed overflow flag.
module digit_adder #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic carry;

    always_comb begin
        s        = '0;
        carry    = cin;
        c_msb_in = cin;
        for (int i = 0; i < int'(DIGIT); i++) begin
            c_msb_in = carry;
            s[i]     = x[i] ^ y[i] ^ carry;
            carry    = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract unit: operands latched on start, processed
// LSB-first DIGIT bits per clock through a single registered carry.
module digit_serial_adder
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    if (!width_ok(WIDTH, DIGIT)) begin : g_bad_cfg
        $error("digit_serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d, overflow_d, busy_d, done_d;

    logic [DIGIT-1:0] dsum;
    logic             dcout, dcmsb;

    digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
        .x        (a_q[DIGIT-1:0]),
        .y        (b_q[DIGIT-1:0]),
        .cin      (carry_q),
        .s        (dsum),
        .cout     (dcout),
        .c_msb_in (dcmsb)
    );

    // Next-state, datapath and output-register logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        sum_d      = sum;
        cout_d     = cout;
        overflow_d = overflow;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dcout;
                acc_d   = WIDTH'({dsum, acc_q} >> DIGIT);
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    sum_d      = acc_d;
                    cout_d     = dcout;
                    overflow_d = dcout ^ dcmsb;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            busy     <= busy_d;
            done     <= done_d;
            sum      <= sum_d;
            cout     <= cout_d;
            overflow <= overflow_d;
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three configurations (8/1, 8/4, 16/2) driven
// by directed steps plus randomized vectors against an arithmetic model.
module tb_digit_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v   [3];
    logic        start_v [3];
    logic        sub_v   [3];
    logic [15:0] a_v     [3];
    logic [15:0] b_v     [3];

    logic [7:0]  sum81, sum84;
    logic [15:0] sum162;
    logic        busy81, busy84, busy162;
    logic        done81, done84, done162;
    logic        cout81, cout84, cout162;
    logic        ovf81, ovf84, ovf162;

    logic [15:0] obs_sum [3];
    logic [2:0]  obs_busy, obs_done, obs_cout, obs_ovf;

    int checks = 0;
    int errors = 0;

    digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u_d81 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .sub(sub_v[0]),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .busy(busy81), .done(done81),
        .sum(sum81), .cout(cout81), .overflow(ovf81)
    );

    digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u_d84 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .sub(sub_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .busy(busy84), .done(done84),
        .sum(sum84), .cout(cout84), .overflow(ovf84)
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(2)) u_d162 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .sub(sub_v[2]),
        .a(a_v[2]), .b(b_v[2]), .busy(busy162), .done(done162),
        .sum(sum162), .cout(cout162), .overflow(ovf162)
    );

    assign obs_sum[0] = {8'h00, sum81};
    assign obs_sum[1] = {8'h00, sum84};
    assign obs_sum[2] = sum162;
    assign obs_busy   = {busy162, busy84, busy81};
    assign obs_done   = {done162, done84, done81};
    assign obs_cout   = {cout162, cout84, cout81};
    assign obs_ovf    = {ovf162, ovf84, ovf81};

    function automatic int width_of(int k);
        return (k == 2) ? 16 : 8;
    endfunction

    function automatic int digits_of(int k);
        return (k == 0) ? 8 : ((k == 1) ? 2 : 8);
    endfunction

    // Returns {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] model(int w, logic [15:0] a, logic [15:0] b, logic sub);
        longint mod, ua, ub, sa, sb, r, sr;
        logic   c, v;
        logic [15:0] s;
        mod = longint'(1) << w;
        ua  = longint'(a) & (mod - 1);
        ub  = longint'(b) & (mod - 1);
        sa  = (ua >= mod / 2) ? ua - mod : ua;
        sb  = (ub >= mod / 2) ? ub - mod : ub;
        if (sub) begin
            r  = ua - ub;
            c  = (ua >= ub);
            sr = sa - sb;
        end else begin
            r  = ua + ub;
            c  = (r >= mod);
            sr = sa + sb;
        end
        s = 16'((r + mod) % mod);
        v = (sr < -(mod / 2)) || (sr >= mod / 2);
        return {v, c, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present operands with start for one edge, then scramble the inputs.
    task automatic issue(int k, logic [15:0] a, logic [15:0] b, logic sub);
        a_v[k]     = a;
        b_v[k]     = b;
        sub_v[k]   = sub;
        start_v[k] = 1'b1;
        tick();
        start_v[k] = 1'b0;
        a_v[k]     = 16'($urandom);
        b_v[k]     = 16'($urandom);
        sub_v[k]   = 1'($urandom);
        chk("busy_after_start", 32'(obs_busy[k]), 32'(1));
    endtask

    task automatic wait_done(int k, output int lat);
        lat = 0;
        while (!obs_done[k] && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_result(int k, string tag, logic [15:0] a, logic [15:0] b, logic sub);
        logic [17:0] m;
        m = model(width_of(k), a, b, sub);
        chk({tag, "_sum"},  32'(obs_sum[k]),  32'(m[15:0]));
        chk({tag, "_cout"}, 32'(obs_cout[k]), 32'(m[16]));
        chk({tag, "_ovf"},  32'(obs_ovf[k]),  32'(m[17]));
        chk({tag, "_busy"}, 32'(obs_busy[k]), 32'(0));
    endtask

    initial begin
        int          lat;
        int          ndone;
        logic [15:0] ra, rb, prev;
        logic        rs;

        for (int k = 0; k < 3; k++) begin
            rst_v[k] = 1'b1; start_v[k] = 1'b0; sub_v[k] = 1'b0;
            a_v[k] = '0; b_v[k] = '0;
        end
        tick();
        tick();
        for (int k = 0; k < 3; k++) rst_v[k] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("reset_sum",  32'(obs_sum[k]),  32'(0));
            chk("reset_busy", 32'(obs_busy[k]), 32'(0));
            chk("reset_done", 32'(obs_done[k]), 32'(0));
            chk("reset_cout", 32'(obs_cout[k]), 32'(0));
            chk("reset_ovf",  32'(obs_ovf[k]),  32'(0));
        end

        // 8/1: basic add
        issue(0, 16'h3C, 16'h5A, 1'b0);
        wait_done(0, lat);
        chk("add81_latency", 32'(lat), 32'(8));
        check_result(0, "add81", 16'h3C, 16'h5A, 1'b0);
        chk("add81_sum_const", 32'(obs_sum[0]), 32'h96);
        tick();
        chk("add81_done_drop", 32'(obs_done[0]), 32'(0));

        // 8/1: subtract, then back-to-back add issued in the DONE cycle
        issue(0, 16'h10, 16'h20, 1'b1);
        wait_done(0, lat);
        chk("sub81_latency", 32'(lat), 32'(8));
        check_result(0, "sub81", 16'h10, 16'h20, 1'b1);
        chk("sub81_sum_const", 32'(obs_sum[0]), 32'hF0);
        issue(0, 16'hFF, 16'h01, 1'b0);
        chk("b2b_done_drop", 32'(obs_done[0]), 32'(0));
        chk("b2b_sum_hold", 32'(obs_sum[0]), 32'hF0);
        wait_done(0, lat);
        chk("b2b_latency", 32'(lat), 32'(8));
        check_result(0, "b2b81", 16'hFF, 16'h01, 1'b0);
        chk("b2b_cout_const", 32'(obs_cout[0]), 32'(1));

        // 8/4: two-digit add with carry-out and overflow
        issue(1, 16'h80, 16'h80, 1'b0);
        wait_done(1, lat);
        chk("add84_latency", 32'(lat), 32'(2));
        check_result(1, "add84", 16'h80, 16'h80, 1'b0);
        chk("add84_ovf_const", 32'(obs_ovf[1]), 32'(1));

        // 8/1: start pulsed during RUN is ignored
        tick();
        issue(0, 16'h3C, 16'h5A, 1'b0);
        tick();
        tick();
        a_v[0] = 16'h77; b_v[0] = 16'h11; sub_v[0] = 1'b1; start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        wait_done(0, lat);
        chk("ignore_latency", 32'(lat + 3), 32'(8));
        check_result(0, "ignore81", 16'h3C, 16'h5A, 1'b0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (obs_done[0]) ndone++;
        end
        chk("ignore_extra_done", 32'(ndone), 32'(0));

        // 8/1: reset mid-RUN discards the operation
        issue(0, 16'h3C, 16'h5A, 1'b0);
        tick();
        tick();
        tick();
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        chk("midrst_busy", 32'(obs_busy[0]), 32'(0));
        chk("midrst_done", 32'(obs_done[0]), 32'(0));
        chk("midrst_sum",  32'(obs_sum[0]),  32'(0));
        chk("midrst_cout", 32'(obs_cout[0]), 32'(0));
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_done[0]) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'(0));
        issue(0, 16'h01, 16'h01, 1'b0);
        wait_done(0, lat);
        chk("postrst_latency", 32'(lat), 32'(8));
        check_result(0, "postrst81", 16'h01, 16'h01, 1'b0);

        // start coincident with reset is dropped
        tick();
        a_v[0] = 16'h05; b_v[0] = 16'h06; start_v[0] = 1'b1; rst_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0; rst_v[0] = 1'b0;
        chk("rststart_busy", 32'(obs_busy[0]), 32'(0));
        chk("rststart_sum",  32'(obs_sum[0]),  32'(0));
        tick();
        chk("rststart_busy2", 32'(obs_busy[0]), 32'(0));

        // 16/2: randomized vectors, mixing back-to-back and idle gaps
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            if (i % 16 == 0) ra = 16'h8000;
            if (i % 16 == 1) rb = 16'hFFFF;
            issue(2, ra, rb, rs);
            wait_done(2, lat);
            chk("rand_latency", 32'(lat), 32'(digits_of(2)));
            check_result(2, "rand162", ra, rb, rs);
            if ($urandom_range(0, 1) == 1) begin
                prev = obs_sum[2];
                tick();
                chk("rand_idle_hold", 32'(obs_sum[2]), 32'(prev));
                chk("rand_idle_done", 32'(obs_done[2]), 32'(0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
